// File: rtl/uart_pkg.sv
// Shared definitions for the UART blocks: transmitter FSM states, frame
// geometry and the baud-divider helper.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Rounded clock cycles per bit for a given system clock and line rate.
  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with first-word fall-through read data.
// Pointers carry one extra MSB so that full and empty can be told apart.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_bad_depth
    $error("sync_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; the pointers alone
  // decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// Buffered UART transmitter: CPU byte writes queue in a FIFO and are sent
// 8N1, or 8E1 when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_ctrl #(
  parameter int CLK_HZ     = 27_000_000,
  parameter int BAUD       = 115_200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          wr_valid,
  input  logic [7:0]                    wr_data,
  output logic                          wr_ready,
  input  logic                          ovf_clr,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          tx
);

  import uart_pkg::*;

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int CNT_W        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST = 3'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_tx_fifo_ctrl: CLKS_PER_BIT must be at least 2");
  end

  tx_state_e            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 overflow_q, overflow_d;
  logic                 pop, bit_end;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic                 fifo_full, fifo_empty;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (resetn),
    .push_i  (wr_valid),
    .wdata_i (wr_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      overflow_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      overflow_q <= overflow_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign bit_end = (cnt_q == CNT_LAST);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = bit_end ? '0 : cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif
    // A refused write sets the flag even when a clear arrives together.
    overflow_d = (wr_valid && fifo_full) ? 1'b1 : (ovf_clr ? 1'b0 : overflow_q);

    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_d   = ST_DATA;
          bit_idx_d = '0;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_idx_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_rdata;
`ifdef UART_TX_PARITY_EN
      parity_d = ^fifo_rdata;
`endif
    end
  end

  // Line level for the coming cycle follows the state being entered.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  assign tx       = tx_q;
  assign overflow = overflow_q;
  assign wr_ready = !fifo_full;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl at 4 clocks per bit, FIFO depth 4;
// expected line waveforms are rebuilt from the byte values.
module tb_uart_tx_fifo_ctrl;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FW = NB * CPB;
  localparam int SN = 512;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       ovf_clr = 1'b0;
  logic       wr_ready, overflow, busy, tx;
  logic [2:0] fifo_level;

  int total = 0;
  int bad   = 0;

  logic       st_v [SN];
  logic [7:0] st_d [SN];
  logic       st_c [SN];
  logic       s_tx [SN];
  logic       s_busy [SN];
  logic       s_rdy [SN];
  logic       s_ovf [SN];
  logic [2:0] s_lvl [SN];

  uart_tx_fifo_ctrl #(
    .CLK_HZ     (1_000_000),
    .BAUD       (250_000),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .busy       (busy),
    .tx         (tx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int j = 0; j < SN; j++) begin
      st_v[j] = 1'b0;
      st_d[j] = 8'h00;
      st_c[j] = 1'b0;
    end
  endtask

  // Sample j is taken 1 time unit after the edge that consumed stimulus j.
  task automatic run(input int n);
    for (int j = 0; j < n; j++) begin
      wr_valid = st_v[j];
      wr_data  = st_d[j];
      ovf_clr  = st_c[j];
      @(posedge clk);
      #1;
      s_tx[j]   = tx;
      s_busy[j] = busy;
      s_rdy[j]  = wr_ready;
      s_ovf[j]  = overflow;
      s_lvl[j]  = fifo_level;
    end
    wr_valid = 1'b0;
    ovf_clr  = 1'b0;
  endtask

  function automatic logic [63:0] exp_wave(input logic [7:0] b);
    logic [10:0] bt;
    logic [63:0] w;
    bt      = 11'h7FF;
    bt[0]   = 1'b0;
    bt[8:1] = b;
`ifdef UART_TX_PARITY_EN
    bt[9]   = ^b;
`endif
    w = '0;
    for (int j = 0; j < FW; j++) w[j] = bt[j / CPB];
    return w;
  endfunction

  function automatic logic [63:0] got_wave(input int off);
    logic [63:0] w;
    w = '0;
    for (int j = 0; j < FW; j++) w[j] = s_tx[off + j];
    return w;
  endfunction

  // Mid-bit sampling, as a receiver would do it.
  function automatic logic [7:0] decode(input int off);
    logic [7:0] d;
    for (int i = 0; i < 8; i++) d[i] = s_tx[off + CPB * (1 + i) + CPB / 2];
    return d;
  endfunction

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_tx", 64'(tx), 64'd1);
    check("rst_ready", 64'(wr_ready), 64'd1);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_level", 64'(fifo_level), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    // Single byte 0x55
    clear_stim();
    st_v[0] = 1'b1; st_d[0] = 8'h55;
    run(FW + 2);
    check("t1_level_k", 64'(s_lvl[0]), 64'd1);
    check("t1_busy_k", 64'(s_busy[0]), 64'd1);
    check("t1_tx_k", 64'(s_tx[0]), 64'd1);
    check("t1_level_pop", 64'(s_lvl[1]), 64'd0);
    check("t1_wave", got_wave(1), exp_wave(8'h55));
    check("t1_busy_last", 64'(s_busy[FW]), 64'd1);
    check("t1_busy_end", 64'(s_busy[FW + 1]), 64'd0);
    check("t1_tx_idle", 64'(s_tx[FW + 1]), 64'd1);

    // Back-to-back 0xA5, 0x3C
    clear_stim();
    st_v[0] = 1'b1; st_d[0] = 8'hA5;
    st_v[1] = 1'b1; st_d[1] = 8'h3C;
    run(2 * FW + 2);
    check("t2_wave0", got_wave(1), exp_wave(8'hA5));
    check("t2_wave1", got_wave(1 + FW), exp_wave(8'h3C));
    check("t2_dec0", 64'(decode(1)), 64'hA5);
    check("t2_dec1", 64'(decode(1 + FW)), 64'h3C);
    check("t2_busy_end", 64'(s_busy[2 * FW + 1]), 64'd0);

    // Full and overflow: six writes, five accepted
    clear_stim();
    for (int j = 0; j < 6; j++) begin
      st_v[j] = 1'b1;
      st_d[j] = 8'(8'h11 * (j + 1));
    end
    st_c[6] = 1'b1;
    run(1 + 5 * FW + 2);
    check("t3_level1", 64'(s_lvl[1]), 64'd1);
    check("t3_ready3", 64'(s_rdy[3]), 64'd1);
    check("t3_level4", 64'(s_lvl[4]), 64'd4);
    check("t3_ready4", 64'(s_rdy[4]), 64'd0);
    check("t3_ovf4", 64'(s_ovf[4]), 64'd0);
    check("t3_ovf5", 64'(s_ovf[5]), 64'd1);
    check("t3_level5", 64'(s_lvl[5]), 64'd4);
    check("t3_ovf_clr", 64'(s_ovf[6]), 64'd0);
    for (int m = 0; m < 5; m++)
      check($sformatf("t3_wave%0d", m), got_wave(1 + m * FW), exp_wave(8'(8'h11 * (m + 1))));
    check("t3_busy_end", 64'(s_busy[1 + 5 * FW]), 64'd0);
    check("t3_level_end", 64'(s_lvl[1 + 5 * FW]), 64'd0);

    // Push while full in the same cycle as a pop at a stop-bit end
    clear_stim();
    for (int j = 0; j < 5; j++) begin
      st_v[j] = 1'b1;
      st_d[j] = 8'(8'hC1 + j);
    end
    st_v[FW + 1] = 1'b1; st_d[FW + 1] = 8'hEE;
    st_c[FW + 2] = 1'b1;
    run(1 + 5 * FW + 2);
    check("t4_level_full", 64'(s_lvl[FW]), 64'd4);
    check("t4_ready_full", 64'(s_rdy[FW]), 64'd0);
    check("t4_ovf_before", 64'(s_ovf[FW]), 64'd0);
    check("t4_level_pop", 64'(s_lvl[FW + 1]), 64'd3);
    check("t4_ovf_set", 64'(s_ovf[FW + 1]), 64'd1);
    check("t4_ready_pop", 64'(s_rdy[FW + 1]), 64'd1);
    check("t4_ovf_clr", 64'(s_ovf[FW + 2]), 64'd0);
    check("t4_wave1", got_wave(1 + FW), exp_wave(8'hC2));
    check("t4_wave4", got_wave(1 + 4 * FW), exp_wave(8'hC5));
    check("t4_busy_end", 64'(s_busy[1 + 5 * FW]), 64'd0);

    // Reset during data bit 3, with a second byte queued
    clear_stim();
    st_v[0] = 1'b1; st_d[0] = 8'hF0;
    st_v[1] = 1'b1; st_d[1] = 8'h12;
    run(19);
    check("t5_tx_bit3", 64'(s_tx[18]), 64'd0);
    check("t5_level_q", 64'(s_lvl[18]), 64'd1);
    #2;
    resetn = 1'b0;
    #1;
    check("t5_async_tx", 64'(tx), 64'd1);
    check("t5_async_level", 64'(fifo_level), 64'd0);
    check("t5_async_busy", 64'(busy), 64'd0);
    check("t5_async_ready", 64'(wr_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    clear_stim();
    st_v[0] = 1'b1; st_d[0] = 8'h01;
    run(FW + 2);
    check("t5_wave", got_wave(1), exp_wave(8'h01));
    check("t5_busy_end", 64'(s_busy[FW + 1]), 64'd0);
    check("t5_level_end", 64'(s_lvl[FW + 1]), 64'd0);

    // Byte 0x07: odd popcount, so an even-parity bit would be 1
    clear_stim();
    st_v[0] = 1'b1; st_d[0] = 8'h07;
    run(FW + 2);
    check("t6_wave", got_wave(1), exp_wave(8'h07));
    check("t6_busy_last", 64'(s_busy[FW]), 64'd1);
    check("t6_busy_end", 64'(s_busy[FW + 1]), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
- Buffered 8N1 UART transmitter. It sits directly downstream of the soc CPU's memory-mapped IO write path, alongside the LED register.
- The CPU pushes bytes into an internal FIFO. The block serialises them on the Tang Nano 9K USB-UART pin.
- Gives firmware a console channel beside the 6 LEDs, with sticky overflow reporting.

Parameters:
- CLK_HZ, 27_000_000, system clock frequency in Hz.
- BAUD, 115_200, line rate in bit/s.
- FIFO_DEPTH, 16, byte entries; must be a power of two, ≥2.
- CLKS_PER_BIT, derived localparam = (CLK_HZ + BAUD/2) / BAUD. Elaboration fails if it is < 2.

Ports:
- clk  in  1  system clock; all flops on rising edge.
- resetn  in  1  asynchronous active-low reset; assert asynchronously, release synchronous to clk.
- wr_valid  in  1  CPU write strobe for a TX byte.
- wr_data  in  8  byte to transmit.
- wr_ready  out  1  FIFO not full; a write is accepted at a clk edge where wr_valid && wr_ready.
- ovf_clr  in  1  clears the overflow flag.
- overflow  out  1  sticky: a write was attempted while wr_ready=0.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently queued, excluding the byte being shifted.
- busy  out  1  FSM not IDLE, or fifo_level != 0.
- tx  out  1  serial line, idle high.

Behaviour:
- Reset values (resetn=0): tx=1, wr_ready=1, overflow=0, fifo_level=0, busy=0, FSM=IDLE, FIFO pointers=0.
  - Reset mid-frame aborts the frame: tx returns to 1 asynchronously and queued bytes are discarded.
- FIFO: circular buffer with read/write pointers of width log2(DEPTH)+1; the extra MSB distinguishes full from empty.
  - wr_ready = !full, registered-equivalent (derived from pointers only, never from wr_valid).
  - Push and pop in the same cycle: level unchanged.
  - When full, wr_ready=0 and pushes are refused even if a pop occurs that cycle.
- Overflow: wr_valid && !wr_ready sets overflow on the next edge; the byte is dropped.
  - ovf_clr clears overflow. If ovf_clr and a new overflow event occur together, set wins.
- Bit timer: counter 0..CLKS_PER_BIT-1; each bit is held exactly CLKS_PER_BIT cycles.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO non-empty, pop into shift register, go to START, tx<=0 (registered).
  - START: tx=0 for one bit time, then DATA with bit index 0.
  - DATA: tx=shift[0], LSB first; shift right each bit time; after bit 7 go to STOP.
  - STOP: tx=1 for one bit time. On the last cycle of STOP: if FIFO non-empty, pop and go directly to START (no idle gap, back-to-back frames); else go to IDLE.
- Latency: write accepted at edge k (FIFO empty, FSM IDLE) → fifo_level=1 after k; pop and tx=0 at edge k+1; frame occupies 10×CLKS_PER_BIT cycles.
- fifo_level decrements at the pop edge.
- wr_data is sampled only on accepted writes; wr_data is don't-care otherwise.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: an even-parity bit is inserted between DATA bit 7 and STOP (new state PARITY, one bit time, tx = ^byte). Frame = 11 bit times (8E1).
- Undefined: no PARITY state or logic; 8N1 with 10 bit-time frames exactly as above.

Decomposition:
- Shared package uart_pkg holds:
  - FSM state enum (IDLE/START/DATA/PARITY/STOP).
  - DATA_BITS=8.
  - function clks_per_bit(clk_hz, baud).
- Natural sub-module: sync_fifo (parameterised width/depth, push/pop/full/empty/level). It is reused later for the RX side.

Test Plan (CLK_HZ=1_000_000, BAUD=250_000 → CLKS_PER_BIT=4, FIFO_DEPTH=4):
- Single byte: write 0x55 at edge k → tx=0 during cycles k+1..k+4, then 1,0,1,0,1,0,1,0 each 4 cycles, then 1 for 4 cycles. busy falls at k+41; fifo_level 1→0 at k+1.
- Back-to-back: write 0xA5,0x3C on consecutive cycles → two contiguous 40-cycle frames, no idle cycle between stop and start. Decoded bytes are 0xA5 then 0x3C.
- Full/overflow: write 6 bytes on consecutive cycles from idle.
  - First byte popped; wr_ready=0 after 5th accepted write (level=4).
  - 6th write dropped and overflow=1.
  - ovf_clr → overflow=0. Only 5 bytes are transmitted.
- Simultaneous push/pop: with level=4 and a pop at a stop-bit end, assert wr_valid → write refused, overflow=1, level=3.
- Reset mid-frame: deassert resetn during DATA bit 3 → tx=1 with no clk edge needed; level=0, busy=0. After release, a write of 0x01 transmits correctly.
- Parity (UART_TX_PARITY_EN): byte 0x07 → parity bit 1 after data, then stop; frame is 44 cycles.
